// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART constants and receiver state encodings.
// Revision : 1.0
// ============================================================================
package uart_pkg;

  localparam int OVERSAMPLE_DEFAULT = 16;
  localparam int DATA_BITS          = 8;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BRK   = 3'd4
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Purpose  : Multi-flop synchroniser for an asynchronous, idle-high input.
// Revision : 1.0
// ============================================================================
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  // Reset to the idle level so no false start bit is seen after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver, oversampled via a clock-enable tick.
// Revision : 1.0
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       rxd,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int                CNT_W    = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        IDX_LAST = 3'(DATA_BITS - 1);

  logic rxs;

  rx_state_e        state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [2:0]       idx_q,       idx_d;
  logic [7:0]       shift_q,     shift_d;
  logic [7:0]       data_q,      data_d;
  logic             valid_q,     valid_d;
  logic             frame_err_q, frame_err_d;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rxs)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    if (enable) begin
      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            state_d = RX_START;
            cnt_d   = '0;
          end
        end
        RX_START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt_q == CNT_HALF) begin
            if (!rxs) begin
              state_d = RX_DATA;
              cnt_d   = '0;
              idx_d   = '0;
            end else begin
              state_d = RX_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            shift_d = {rxs, shift_q[7:1]};
            cnt_d   = '0;
            if (idx_q == IDX_LAST) state_d = RX_STOP;
            else                   idx_d   = idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = RX_IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = RX_BRK;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RX_BRK: begin
          // Hold here until the line returns high so a break reports once.
          if (rxs) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != RX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx driving an emulated uart_tx line.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       rxd;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .rxd       (rxd),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One oversample tick spans four clocks; enable is high for one of them.
  task automatic tick();
    @(negedge clk) enable = 1'b1;
    @(negedge clk) enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Emulated transmitter: start, 8 data bits LSB first, stop; bt ticks per bit.
  task automatic send(input logic [7:0] b, input int bt, input logic stop_bit, input int nsym);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int s = 0; s < nsym; s++) begin
      rxd = f[s];
      ticks(bt);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%b frame_err=%b data_out=%h, no event expected",
                   valid, frame_err, data_out);
        end else begin
          e = exp_q.pop_front();
          check("pulse_is_frame_err", {7'b0, frame_err}, {7'b0, e.is_err});
          check("pulse_is_valid", {7'b0, valid}, {7'b0, ~e.is_err});
          check(e.is_err ? "err_data_held" : "rx_data", data_out, e.data);
        end
      end
    end
  end

  initial begin : stimulus
    reset  = 1'b0;
    enable = 1'b0;
    rxd    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 8'h00);
    check("reset_valid", {7'b0, valid}, 8'h00);
    check("reset_frame_err", {7'b0, frame_err}, 8'h00);
    check("reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b1;
    ticks(4);

    // Short low glitch: rejected at mid start bit.
    rxd = 1'b0;
    ticks(3);
    check("glitch_busy_start", {7'b0, busy}, 8'h01);
    ticks(2);
    rxd = 1'b1;
    ticks(8);
    check("glitch_back_idle", {7'b0, busy}, 8'h00);

    // Stop bit low: one frame_err, data_out keeps reset value, sits in BRK.
    exp_q.push_back(exp_t'{1'b1, 8'h00});
    send(8'h55, 16, 1'b0, 10);
    ticks(16);
    check("brk_busy_while_low", {7'b0, busy}, 8'h01);
    rxd = 1'b1;
    ticks(4);
    check("brk_exit_idle", {7'b0, busy}, 8'h00);
    check("brk_events_seen", 8'(exp_q.size()), 8'h00);

    // Back-to-back frames.
    exp_q.push_back(exp_t'{1'b0, 8'hA5});
    exp_q.push_back(exp_t'{1'b0, 8'h3C});
    send(8'hA5, 16, 1'b1, 10);
    send(8'h3C, 16, 1'b1, 10);
    ticks(16);
    check("b2b_events_seen", 8'(exp_q.size()), 8'h00);

    // Line break for 40 bit periods: exactly one frame_err, then a good frame.
    exp_q.push_back(exp_t'{1'b1, 8'h3C});
    rxd = 1'b0;
    ticks(40 * 16);
    check("break_busy", {7'b0, busy}, 8'h01);
    rxd = 1'b1;
    ticks(16);
    check("break_single_err", 8'(exp_q.size()), 8'h00);
    exp_q.push_back(exp_t'{1'b0, 8'hFF});
    send(8'hFF, 16, 1'b1, 10);
    ticks(16);
    check("after_break_events_seen", 8'(exp_q.size()), 8'h00);

    // Reset in the middle of a frame's data bits.
    send(8'h0F, 16, 1'b1, 5);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("abort_busy_in_reset", {7'b0, busy}, 8'h00);
    check("abort_data_in_reset", data_out, 8'h00);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ticks(4);
    check("abort_idle_after", {7'b0, busy}, 8'h00);
    exp_q.push_back(exp_t'{1'b0, 8'hF0});
    send(8'hF0, 16, 1'b1, 10);
    ticks(16);
    check("abort_events_seen", 8'(exp_q.size()), 8'h00);

    // Baud skew: slow and fast transmitter.
    exp_q.push_back(exp_t'{1'b0, 8'hC3});
    send(8'hC3, 17, 1'b1, 10);
    ticks(16);
    check("slow_events_seen", 8'(exp_q.size()), 8'h00);
    exp_q.push_back(exp_t'{1'b0, 8'hC3});
    send(8'hC3, 15, 1'b1, 10);
    ticks(16);
    check("fast_events_seen", 8'(exp_q.size()), 8'h00);
    check("final_busy", {7'b0, busy}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver; downstream peer of the team's uart_tx, consuming its txd line.
- Oversamples the serial line at OVERSAMPLE x baud via a clock-enable tick.
- Resynchronises the line, qualifies the start bit at mid-bit and samples each data bit at its centre (LSB first).
- Checks the stop bit and presents the byte with a one-cycle valid pulse, or flags a framing error.

Parameters:
OVERSAMPLE, 16, enable ticks per bit period; even, >=4.
SYNC_STAGES, 2, flops in the rxd synchroniser; >=2.

Ports:
clk  input  1  system clock.
reset  input  1  asynchronous, active-low reset.
enable  input  1  oversample tick, one clk wide, OVERSAMPLE x baud. Paired uart_tx enable = every OVERSAMPLE-th rx tick.
rxd  input  1  asynchronous serial line; idle high.
data_out  output  8  last correctly framed byte; held until the next good frame.
valid  output  1  one-clk pulse: data_out updated this cycle.
frame_err  output  1  one-clk pulse: stop bit sampled low.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, sample cnt=0, bit idx=0, shift reg=0, synchroniser flops=1, data_out=0, valid=0, frame_err=0, busy=0. Reset mid-frame aborts with no valid/frame_err.
- Synchroniser runs every clk, ungated. rxs = last stage. FSM and counters advance only when enable=1.
- valid and frame_err default to 0 on every clk, independent of enable, so each pulse lasts exactly one clk.
- State transitions (on enable):
  - IDLE: rxs=0 -> START, cnt=0.
  - START: cnt++. At cnt==OVERSAMPLE/2-1 (mid start bit): rxs=0 -> DATA, cnt=0, idx=0; rxs=1 -> IDLE (glitch rejected, no flags).
  - DATA: cnt++. At cnt==OVERSAMPLE-1: shift = {rxs, shift[7:1]}, cnt=0; idx==7 -> STOP, else idx++.
  - STOP: cnt++. At cnt==OVERSAMPLE-1:
    - rxs=1: data_out=shifted byte, valid=1 -> IDLE.
    - rxs=0: frame_err=1, data_out unchanged -> BRK.
  - BRK: wait while rxs=0. rxs=1 -> IDLE. A held-low line (break) yields exactly one frame_err, not repeated frames.
- Sample points: data bit n sampled (OVERSAMPLE/2 + (n+1)*OVERSAMPLE) ticks after the first low tick, i.e. bit centre.
- Latency: valid asserts in the clk of the stop-bit centre tick. Synchroniser adds SYNC_STAGES clk.
- Tolerance: rx/tx baud mismatch up to +/-3% must receive correctly.
- Back-to-back frames: after valid, IDLE detects the next start bit on the first enable with rxs=0. No extra idle time is required beyond a half stop bit.
- Boundary conditions:
  - enable=0 freezes cnt/idx/state; pulses still self-clear.
  - rxd changes between ticks are ignored except through the synchroniser.
  - cnt is 4 bits for the default; width = clog2(OVERSAMPLE).
- Encodings: states IDLE=0, START=1, DATA=2, STOP=3, BRK=4 (3-bit).

Decomposition:
- Shared package uart_pkg: rx state encodings, default OVERSAMPLE, frame constants (DATA_BITS=8).
- One sub-module uart_rx_sync: SYNC_STAGES-deep synchroniser with async active-low reset to 1. Shared later by other async inputs.

Test Plan:
- Loopback with uart_tx, tx enable = rx enable/16, send 8'hA5 then 8'h3C back-to-back -> two valid pulses, data_out=8'hA5 then 8'h3C, frame_err never 1.
- rxd low for 5 ticks then high (glitch shorter than OVERSAMPLE/2) -> returns to IDLE, busy drops, no valid, no frame_err.
- Frame 8'h55 with stop bit forced low -> frame_err pulses once, data_out keeps its previous value (0 after reset), state BRK until rxd=1.
- rxd held low for 40 bit periods (break), then high, then frame 8'hFF -> exactly one frame_err, then valid with data_out=8'hFF.
- Reset asserted mid-DATA of frame 8'h0F, released, then frame 8'hF0 sent -> no pulse from the aborted frame, valid with 8'hF0.
- Bit periods stretched to 17 ticks (+6.25% skew on the 16-tick nominal) and shrunk to 15 ticks for 8'hC3 -> valid with data_out=8'hC3 in both cases.
